// File: rtl/instr_queue.sv
// instr_queue -- circular first-word-fall-through instruction queue that sits
// between the fetch state machine and the decode stage.
//
// Parameters
//   WIDTH     instruction word width in bits
//   DEPTH     number of entries (power of two, minimum 2)
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   reset      asynchronous, active-low reset
//   load_en    push request from fetch
//   in         instruction word to push
//   pop        decode consumes the head entry
//   flush      discard all entries (branch or jump taken), highest priority
//   out        head instruction word, 0 while empty
//   out_valid  out holds a valid entry
//   full       count == DEPTH
//   empty      count == 0
//   count      number of occupied entries
//   overflow   one-cycle pulse after a push was dropped because the queue was full
module instr_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_en,
    input  logic [WIDTH-1:0]           in,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           out,
    output logic                       out_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             ovf;

    logic is_full;
    logic is_empty;
    logic pop_ok;
    logic push_ok;
    logic push_drop;

    assign is_full  = (cnt == CW'(DEPTH));
    assign is_empty = (cnt == '0);

    // A pop on an empty queue is ignored, so a simultaneous push and pop on
    // an empty queue degenerates to a plain push (no bypass to out).
    assign pop_ok    = pop && !is_empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ok   = load_en && (!is_full || pop_ok);
    assign push_drop = load_en && !push_ok;

    // Pointers wrap naturally: DEPTH is a power of two, so PW-bit increments
    // roll over from DEPTH-1 to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      cnt <= cnt + 1'b1;
            else if (pop_ok && !push_ok) cnt <= cnt - 1'b1;
            ovf <= push_drop;
        end
    end

    // Storage is deliberately not reset or cleared on flush; only the
    // pointers and count decide what is visible.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= in;
    end

    assign out       = is_empty ? '0 : mem[rd_ptr];
    assign out_valid = !is_empty;
    assign full      = is_full;
    assign empty     = is_empty;
    assign count     = cnt;
    assign overflow  = ovf;

endmodule
